// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared constants, types and helpers for the pipelined CLA adder
package cla_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Width of one carry-lookahead group (one cla4 instance)
    localparam int GROUP_W = 4;

    // Group propagate/generate pair
    typedef struct packed {
        logic p;
        logic g;
    } pg_t;

    // Merge a more-significant group (hi) with a less-significant span (lo)
    function automatic pg_t pg_combine(input pg_t hi, input pg_t lo);
        pg_t r;
        r.p = hi.p & lo.p;
        r.g = hi.g | (hi.p & lo.g);
        return r;
    endfunction

    // Each stage must hold a whole number of 4-bit groups
    function automatic bit geometry_ok(input int width, input int stages);
        return (stages > 0) && (width > 0) && ((width % (GROUP_W * stages)) == 0);
    endfunction

endpackage

// File: rtl/cla4.sv
// rtl/cla4.sv - 4-bit combinational carry-lookahead group with group P/G
module cla4
    import cla_pkg::*;
(
    input  logic [GROUP_W-1:0] a,
    input  logic [GROUP_W-1:0] b,
    input  logic               ci,
    output logic [GROUP_W-1:0] sum,
    output logic               p,
    output logic               g
);

    logic [GROUP_W-1:0] pi;
    logic [GROUP_W-1:0] gi;
    logic [GROUP_W-1:0] c;

    assign pi = a ^ b;
    assign gi = a & b;

    // Every internal carry is a flat two-level expression of the bit P/G and ci
    assign c[0] = ci;
    assign c[1] = gi[0] | (pi[0] & ci);
    assign c[2] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & ci);
    assign c[3] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0])
                | (pi[2] & pi[1] & pi[0] & ci);

    assign sum = pi ^ c;
    assign p   = &pi;
    assign g   = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1])
               | (pi[3] & pi[2] & pi[1] & gi[0]);

endmodule

// File: rtl/pipelined_cla_adder.sv
// rtl/pipelined_cla_adder.sv - STAGES-deep pipelined CLA adder/subtractor with valid/ready flow control
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SW = WIDTH / STAGES;
    localparam int NG = SW / GROUP_W;

    if (!geometry_ok(WIDTH, STAGES)) begin : g_bad_geometry
        $error("pipelined_cla_adder: WIDTH must be a multiple of 4*STAGES");
    end

    // Subtraction is a + ~b + !ci; everything downstream only sees the inverted form
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    assign b_eff   = (sub == MODE_SUB) ? ~b : b;
    assign cin_eff = (sub == MODE_SUB) ? ~ci : ci;

    // Per-stage occupancy and flow control
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] vin;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] ld;

    for (genvar k = 0; k < STAGES; k++) begin : g_flow
        if (k == 0) begin : g_first
            assign vin[k] = in_valid;
        end else begin : g_rest
            assign vin[k] = v_q[k-1];
        end
        // A stage can move when any slot from here to the output is empty or the output drains
        assign adv[k] = out_ready | ~(&v_q[STAGES-1:k]);
        assign ld[k]  = adv[k] & vin[k];
    end

    // Valid bits shift forward on advance; a stalled stage keeps its bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (adv[k]) begin
                    v_q[k] <= vin[k];
                end
            end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = v_q[STAGES-1];

    // Slice j is both the bit range [j*SW +: SW] and the stage that computes it
    for (genvar j = 0; j < STAGES; j++) begin : g_slice
        logic [SW-1:0] a_op;
        logic [SW-1:0] b_op;
        logic          c_in;
        logic [SW-1:0] s_comb;
        logic [NG:0]   gc;
        logic [NG-1:0] gp;
        logic [NG-1:0] gg;
        logic          carry_q;

        if (j == 0) begin : g_head
            assign a_op = a[j*SW +: SW];
            assign b_op = b_eff[j*SW +: SW];
            assign c_in = cin_eff;
        end else begin : g_skew
            logic [SW-1:0] a_sk [1:j];
            logic [SW-1:0] b_sk [1:j];

            for (genvar d = 1; d <= j; d++) begin : g_tap
                if (d == 1) begin : g_entry
                    // Operands enter the skew line alongside the beat entering stage 0
                    always_ff @(posedge clk or negedge rst_n) begin
                        if (!rst_n) begin
                            a_sk[d] <= '0;
                            b_sk[d] <= '0;
                        end else if (ld[d-1]) begin
                            a_sk[d] <= a[j*SW +: SW];
                            b_sk[d] <= b_eff[j*SW +: SW];
                        end
                    end
                end else begin : g_follow
                    // Operands move one stage further in lockstep with their beat
                    always_ff @(posedge clk or negedge rst_n) begin
                        if (!rst_n) begin
                            a_sk[d] <= '0;
                            b_sk[d] <= '0;
                        end else if (ld[d-1]) begin
                            a_sk[d] <= a_sk[d-1];
                            b_sk[d] <= b_sk[d-1];
                        end
                    end
                end
            end

            assign a_op = a_sk[j];
            assign b_op = b_sk[j];
            assign c_in = g_slice[j-1].carry_q;
        end

        for (genvar i = 0; i < NG; i++) begin : g_grp
            cla4 u_cla4 (
                .a   (a_op[i*GROUP_W +: GROUP_W]),
                .b   (b_op[i*GROUP_W +: GROUP_W]),
                .ci  (gc[i]),
                .sum (s_comb[i*GROUP_W +: GROUP_W]),
                .p   (gp[i]),
                .g   (gg[i])
            );
        end

        // Group carries from the prefix of group P/G terms, never from lower sums
        always_comb begin
            pg_t acc;
            acc = '{p: 1'b1, g: 1'b0};
            gc  = '0;
            for (int i = 0; i < NG; i++) begin
                gc[i] = acc.g | (acc.p & c_in);
                acc   = pg_combine(pg_t'{p: gp[i], g: gg[i]}, acc);
            end
            gc[NG] = acc.g | (acc.p & c_in);
        end

        // Slice carry-out feeds the next stage; the last one is the adder's cout
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                carry_q <= 1'b0;
            end else if (ld[j]) begin
                carry_q <= gc[NG];
            end
        end

        // Result deskew: this slice's sum rides along until the beat leaves the last stage
        logic [SW-1:0] r_sk [j:STAGES-1];

        for (genvar d = j; d < STAGES; d++) begin : g_res
            if (d == j) begin : g_capture
                // Capture the freshly computed slice sum
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_sk[d] <= '0;
                    end else if (ld[d]) begin
                        r_sk[d] <= s_comb;
                    end
                end
            end else begin : g_carry_fwd
                // Carry an earlier slice's sum forward with its beat
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_sk[d] <= '0;
                    end else if (ld[d]) begin
                        r_sk[d] <= r_sk[d-1];
                    end
                end
            end
        end

        assign sum[j*SW +: SW] = r_sk[STAGES-1];

        if (j == STAGES - 1) begin : g_tail
            logic c_msb;
            logic ovf_q;

            // Carry into the MSB recovered from its sum bit and operand bits
            assign c_msb = s_comb[SW-1] ^ a_op[SW-1] ^ b_op[SW-1];

            // Signed overflow: carry into MSB disagrees with carry out of MSB
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (ld[j]) begin
                    ovf_q <= c_msb ^ gc[NG];
                end
            end

            assign ovf  = ovf_q;
            assign cout = carry_q;
        end
    end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb/tb_pipelined_cla_adder.sv - self-checking bench for pipelined_cla_adder
module tb_pipelined_cla_adder;

    localparam int W = 16;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ci = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    pipelined_cla_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [17:0] exp_q[$];
    logic        accepted;
    logic        popped;
    logic [17:0] last_pop;
    logic        held_valid = 1'b0;
    logic [17:0] held_val;
    int          ready_lows = 0;
    int          spurious = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: plain integer arithmetic; returns {ovf, cout, sum}
    function automatic logic [17:0] model(input logic [15:0] av, input logic [15:0] bv,
                                          input logic civ, input logic subv);
        int ua, ub, c, sa, sb, sr;
        logic [15:0] s;
        logic co, ov;
        ua = int'(av);
        ub = int'(bv);
        c  = civ ? 1 : 0;
        sa = $signed(av);
        sb = $signed(bv);
        if (subv) begin
            s  = 16'(ua - ub - c);
            co = (ua >= ub + c);
            sr = sa - sb - c;
        end else begin
            s  = 16'(ua + ub + c);
            co = ((ua + ub + c) > 65535);
            sr = sa + sb + c;
        end
        ov = (sr > 32767) || (sr < -32768);
        return {ov, co, s};
    endfunction

    // One clock cycle: observe at negedge, then step past the rising edge
    task automatic tick();
        accepted = 1'b0;
        popped   = 1'b0;
        @(negedge clk);
        if (rst_n) begin
            chk("in_ready", in_ready, out_ready || (exp_q.size() < S));
            if (!in_ready) ready_lows++;
            if (out_valid && exp_q.size() == 0) spurious++;
            if (out_valid && !out_ready) begin
                if (held_valid) chk("stall_hold", {ovf, cout, sum}, held_val);
                held_valid = 1'b1;
                held_val   = {ovf, cout, sum};
            end else begin
                held_valid = 1'b0;
            end
            if (out_valid && out_ready) begin
                popped   = 1'b1;
                last_pop = {ovf, cout, sum};
                if (exp_q.size() > 0) chk("result", {ovf, cout, sum}, exp_q.pop_front());
            end
            if (in_valid && in_ready) begin
                accepted = 1'b1;
                exp_q.push_back(model(a, b, ci, sub));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_single(input string tag, input logic [15:0] av, input logic [15:0] bv,
                              input logic civ, input logic subv,
                              input logic [15:0] es, input logic eco, input logic eov);
        int n;
        a = av; b = bv; ci = civ; sub = subv;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        a = $urandom; b = $urandom;
        n = 1;
        while (!popped && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, n - 1, S);
        chk({tag, "_sum"}, last_pop[15:0], es);
        chk({tag, "_cout"}, last_pop[16], eco);
        chk({tag, "_ovf"}, last_pop[17], eov);
        tick();
    endtask

    initial begin
        int first, last, cnt, sent, got;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        tick();

        run_single("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_single("add_ovf", 16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_single("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_single("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // 50 back-to-back random beats with out_ready held high
        first = -1; last = -1; cnt = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            in_valid = (i < 50);
            a = $urandom; b = $urandom; ci = $urandom_range(0, 1); sub = $urandom_range(0, 1);
            tick();
            if (popped) begin
                if (first < 0) first = i;
                last = i;
                cnt++;
            end
        end
        in_valid = 1'b0;
        chk("rand_first_latency", first, S);
        chk("rand_no_gaps", last - first + 1, 50);
        chk("rand_count", cnt, 50);

        // Burst of 8 with downstream stalled in cycles 2..7
        sent = 0; got = 0; ready_lows = 0;
        for (int c = 0; c < 30; c++) begin
            out_ready = !(c >= 2 && c <= 7);
            in_valid  = (sent < 8);
            a = $urandom; b = $urandom; ci = $urandom_range(0, 1); sub = $urandom_range(0, 1);
            tick();
            if (accepted) sent++;
            if (popped) got++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("burst_count", got, 8);
        chk("burst_backpressure", (ready_lows > 0), 1);
        chk("burst_drained", exp_q.size(), 0);

        // Reset with three beats in flight, the oldest sitting at the output
        out_ready = 1'b0;
        a = 16'h1234; b = 16'h1111; ci = 1'b0; sub = 1'b0;
        in_valid = 1'b1;
        repeat (3) tick();
        in_valid = 1'b0;
        repeat (2) tick();
        chk("pre_reset_valid", out_valid, 1);
        chk("pre_reset_sum", sum, 16'h2345);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_sum", sum, 0);
        chk("mid_rst_cout", cout, 0);
        chk("mid_rst_ovf", ovf, 0);
        exp_q.delete();
        held_valid = 1'b0;
        spurious = 0;
        rst_n = 1'b1;
        chk("post_rst_in_ready", in_ready, 1);
        out_ready = 1'b1;
        got = 0;
        repeat (10) begin
            tick();
            if (popped) got++;
        end
        chk("no_stale_result", got, 0);
        chk("no_spurious_valid", spurious, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
